// File: rtl/lab_display_pkg.sv
// Shared definitions for the lab display blocks: speed selects, active-low
// 7-segment glyphs (bit 0 = segment a) and digit limits for hex/BCD counting.
package lab_display_pkg;

  localparam logic [1:0] SPEED_FAST    = 2'b00;
  localparam logic [1:0] SPEED_1HZ     = 2'b01;
  localparam logic [1:0] SPEED_HALF    = 2'b10;
  localparam logic [1:0] SPEED_QUARTER = 2'b11;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  localparam logic [3:0] HEX_MAX = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_glyph.sv
// One hex digit to active-low 7-segment pattern (bit 0 = segment a).
module seg7_glyph
  import lab_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; the case is full so no default path is needed for latches.
  always_comb begin
    case (digit_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      default: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/rate_counter_display.sv
// Multi-digit up/down hex/BCD counter advanced by a switch-selected rate
// divider, with parallel load, wrap flag and direct active-low HEX outputs.
// Optional macro RATE_COUNTER_BLANK_EN enables leading-zero blanking on segs.
module rate_counter_display
  import lab_display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int CLK_HZ     = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              speed,
  input  logic                    up,
  input  logic                    bcd,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    step,
  output logic                    wrap,
  output logic [7*NUM_DIGITS-1:0] segs
);

  localparam int CW    = 4 * NUM_DIGITS;
  localparam int DIV_W = $clog2(4 * CLK_HZ);

  function automatic logic [DIV_W-1:0] reload(input logic [1:0] sel);
    case (sel)
      SPEED_FAST: return '0;
      SPEED_1HZ:  return DIV_W'(CLK_HZ - 1);
      SPEED_HALF: return DIV_W'(2 * CLK_HZ - 1);
      default:    return DIV_W'(4 * CLK_HZ - 1);
    endcase
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       speed_q;
  logic             bcd_q;
  logic [CW-1:0]    count_q, count_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             carry;
  logic [3:0]       digit_max;
  logic [3:0]       dig;

  // Divider: a speed change restarts the period without ticking; otherwise
  // count down while enabled and tick on the reload edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    div_d = div_q;
    tick  = 1'b0;
    if (speed != speed_q) begin
      div_d = reload(speed);
    end else if (enable) begin
      if (div_q == '0) begin
        tick  = 1'b1;
        div_d = reload(speed_q);
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  // Counter next state: load beats a radix change, which beats a tick.
  always_comb begin
    count_d   = count_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    carry     = 1'b1;
    dig       = '0;
    digit_max = bcd ? BCD_MAX : HEX_MAX;
    if (load) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = load_value[4*k +: 4];
        count_d[4*k +: 4] = (bcd && dig > BCD_MAX) ? BCD_MAX : dig;
      end
    end else if (bcd != bcd_q) begin
      count_d = '0;
    end else if (tick) begin
      step_d = 1'b1;
      // Ripple from digit 0; a carry/borrow out of the top digit is a wrap.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (carry) begin
          if (up) begin
            if (dig == digit_max) begin
              count_d[4*k +: 4] = '0;
            end else begin
              count_d[4*k +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == '0) begin
              count_d[4*k +: 4] = digit_max;
            end else begin
              count_d[4*k +: 4] = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  // State registers with synchronous reset; the divider restarts a full period.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      div_q   <= reload(speed);
      speed_q <= speed;
      bcd_q   <= bcd;
      count_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed;
      bcd_q   <= bcd;
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign wrap  = wrap_q;

  // One glyph decoder per digit, optionally blanking leading zeros above digit 0.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] glyph;

    seg7_glyph u_glyph (
      .digit_i (count_q[4*k +: 4]),
      .seg_o   (glyph)
    );

`ifdef RATE_COUNTER_BLANK_EN
    if (k == 0) begin : g_lsd
      assign segs[7*k +: 7] = glyph;
    end else begin : g_upper
      assign segs[7*k +: 7] = (count_q[CW-1:4*k] == '0) ? BLANK_SEG : glyph;
    end
`else
    assign segs[7*k +: 7] = glyph;
`endif
  end

endmodule

// File: tb/tb_rate_counter_display.sv
// Self-checking bench for rate_counter_display (NUM_DIGITS=2, CLK_HZ=4).
// The reference model keeps the count as an integer in radix 10 or 16 and the
// divider as an elapsed-cycle counter against the selected period.
module tb_rate_counter_display;

  localparam int ND = 2;
  localparam int HZ = 4;
  localparam int CW = 4 * ND;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clock = 1'b0;
  logic          reset, enable, up, bcd, load;
  logic [1:0]    speed;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count;
  logic          step, wrap;
  logic [7*ND-1:0] segs;

  int tests = 0;
  int fails = 0;

  int       m_val     = 0;
  int       m_elapsed = 0;
  logic [1:0] m_spd   = 2'b00;
  logic     m_bcd     = 1'b0;
  logic     m_step    = 1'b0;
  logic     m_wrap    = 1'b0;

  always #5 clock = ~clock;

  rate_counter_display #(.NUM_DIGITS(ND), .CLK_HZ(HZ)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .speed      (speed),
    .up         (up),
    .bcd        (bcd),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .step       (step),
    .wrap       (wrap),
    .segs       (segs)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return HZ;
      2'd2:    return 2 * HZ;
      default: return 4 * HZ;
    endcase
  endfunction

  function automatic logic [CW-1:0] encode(input int v, input int r);
    logic [CW-1:0] c;
    int x;
    c = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      c[4*i +: 4] = 4'(x % r);
      x = x / r;
    end
    return c;
  endfunction

  function automatic int decode(input logic [CW-1:0] c, input int r);
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * r + int'(c[4*i +: 4]);
    return v;
  endfunction

  function automatic int full_scale(input int r);
    int m;
    m = 1;
    for (int i = 0; i < ND; i++) m = m * r;
    return m;
  endfunction

  function automatic logic [7*ND-1:0] exp_segs(input logic [CW-1:0] c);
    logic [7*ND-1:0] s;
    for (int k = 0; k < ND; k++) begin
      s[7*k +: 7] = GLYPH[c[4*k +: 4]];
`ifdef RATE_COUNTER_BLANK_EN
      if (k > 0 && (c >> (4 * k)) == '0) s[7*k +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    int r;
    logic tk;
    logic [CW-1:0] lv;
    if (reset) begin
      m_val = 0; m_elapsed = 0; m_spd = speed; m_bcd = bcd; m_step = 1'b0; m_wrap = 1'b0;
    end else begin
      tk = 1'b0;
      if (speed != m_spd) begin
        m_spd = speed;
        m_elapsed = 0;
      end else if (enable) begin
        if (m_elapsed == period(m_spd) - 1) begin
          tk = 1'b1;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      m_step = 1'b0;
      m_wrap = 1'b0;
      r = bcd ? 10 : 16;
      if (load) begin
        lv = load_value;
        for (int i = 0; i < ND; i++) if (bcd && lv[4*i +: 4] > 4'd9) lv[4*i +: 4] = 4'd9;
        m_val = decode(lv, r);
      end else if (bcd != m_bcd) begin
        m_val = 0;
      end else if (tk) begin
        m_step = 1'b1;
        if (up) begin
          m_val = m_val + 1;
          if (m_val == full_scale(r)) begin m_val = 0; m_wrap = 1'b1; end
        end else if (m_val == 0) begin
          m_val = full_scale(r) - 1;
          m_wrap = 1'b1;
        end else begin
          m_val = m_val - 1;
        end
      end
      m_bcd = bcd;
    end
  endtask

  // One clock: update the model, then compare all outputs 1 ns after the edge.
  task automatic cycle();
    logic [CW-1:0] ec;
    model_edge();
    @(posedge clock);
    #1;
    ec = encode(m_val, m_bcd ? 10 : 16);
    check("cyc_count", 64'(count), 64'(ec));
    check("cyc_step", 64'(step), 64'(m_step));
    check("cyc_wrap", 64'(wrap), 64'(m_wrap));
    check("cyc_segs", 64'(segs), 64'(exp_segs(ec)));
  endtask

  initial begin
    int n;
    logic [7*ND-1:0] s;

    // Reset asserted together with load: reset wins.
    reset = 1'b1; enable = 1'b1; speed = 2'b01; up = 1'b1; bcd = 1'b0;
    load = 1'b1; load_value = 8'h55;
    cycle();
    cycle();
    check("reset_count", 64'(count), 64'h00);
    check("reset_step", 64'(step), 64'h0);
    check("reset_wrap", 64'(wrap), 64'h0);

    // 1 Hz at CLK_HZ=4: first step 4 clocks after reset, then every 4.
    reset = 1'b0; load = 1'b0;
    n = 0;
    for (int i = 1; i <= 66; i++) begin
      cycle();
      if (n == 0 && step === 1'b1) n = i;
    end
    check("first_step_latency", 64'(n), 64'd4);
    check("count_after_16_steps", 64'(count), 64'h10);

    // Enable pause mid-period: no lost or extra step.
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (step === 1'b1) begin n = i; break; end
    end
    check("align_step_found", 64'(n != 0), 64'h1);
    cycle();
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (step === 1'b1) begin n = i; break; end
    end
    check("resume_step_latency", 64'(n), 64'd2);

    // Speed change 01 -> 11 mid-period: no step that cycle, next in 16.
    cycle();
    speed = 2'b11;
    cycle();
    check("speed_change_no_step", 64'(step), 64'h0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (step === 1'b1) begin n = i; break; end
    end
    check("quarter_hz_latency", 64'(n), 64'd16);

    // Hex up wrap from FE at the fast rate.
    speed = 2'b00; load = 1'b1; load_value = 8'hFE;
    cycle();
    load = 1'b0;
    cycle();
    check("fe_first_tick", 64'(count), 64'hFF);
    check("fe_first_wrap", 64'(wrap), 64'h0);
    cycle();
    check("wrap_count", 64'(count), 64'h00);
    check("wrap_flag", 64'(wrap), 64'h1);
    s = segs;
    check("wrap_segs_d0", 64'(s[6:0]), 64'h40);

    // BCD down wrap from 00, then clamped load.
    bcd = 1'b1; up = 1'b0; load = 1'b1; load_value = 8'h00;
    cycle();
    load = 1'b0;
    cycle();
    check("bcd_down_count", 64'(count), 64'h99);
    check("bcd_down_wrap", 64'(wrap), 64'h1);
    load = 1'b1; load_value = 8'hAB;
    cycle();
    check("bcd_clamp_count", 64'(count), 64'h99);
    check("bcd_clamp_step", 64'(step), 64'h0);

    // Display of 05 and 00 with the counter held.
    enable = 1'b0; bcd = 1'b0; load_value = 8'h05;
    cycle();
    s = segs;
    check("disp05_d0", 64'(s[6:0]), 64'h12);
`ifdef RATE_COUNTER_BLANK_EN
    check("disp05_d1_blank", 64'(s[13:7]), 64'h7F);
`else
    check("disp05_d1_zero", 64'(s[13:7]), 64'h40);
`endif
    load_value = 8'h00;
    cycle();
    s = segs;
    check("disp00_d0", 64'(s[6:0]), 64'h40);

    // Reset mid-run with load asserted.
    enable = 1'b1; speed = 2'b01; up = 1'b1; load_value = 8'h77;
    reset = 1'b1;
    cycle();
    check("reset_load_count", 64'(count), 64'h00);
    reset = 1'b0; load = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 19) == 0);
      load_value = CW'($urandom);
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bcd = ~bcd;
      if ($urandom_range(0, 9) == 0)  up = ~up;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
